// File: rtl/fifo_wptr_full_pkg.sv
// Shared constants for the dual-clock FIFO pointer stages.
// FIFO_ALMOST_FULL_EN, when defined project-wide, enables the almost-full flag.
package fifo_wptr_full_pkg;

    localparam int A_LENGTH = 3;
    localparam int PTR_W    = A_LENGTH + 1;

endpackage

// File: rtl/fifo_wptr_full_sync.sv
// Two-flop synchroniser with synchronous active-low reset.
// Shared by the write- and read-side pointer stages.
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q1_q;
    logic [W-1:0] q2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d_i;
            q2_q <= q1_q;
        end
    end

    assign q_o = q2_q;

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, Gray publish and full/overflow flags of the async FIFO.
// Optional almost-full output under FIFO_ALMOST_FULL_EN.
module fifo_wptr_full
    import fifo_wptr_full_pkg::*;
#(
    parameter int ADDR_W = A_LENGTH
`ifdef FIFO_ALMOST_FULL_EN
    ,
    parameter int AF_THRESH = (1 << ADDR_W) - 2
`endif
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              winc,
    input  logic [ADDR_W:0]   rptr_gray,
    output logic [ADDR_W-1:0] waddr,
    output logic              wen,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              wfull,
`ifdef FIFO_ALMOST_FULL_EN
    output logic              walmost_full,
`endif
    output logic              wovf
);

    localparam int WP = ADDR_W + 1;

    logic [WP-1:0] wbin_q;
    logic [WP-1:0] wbin_d;
    logic [WP-1:0] wgray_q;
    logic [WP-1:0] wgray_d;
    logic [WP-1:0] rq2;
    logic          wfull_q;
    logic          wfull_d;
    logic          wovf_q;
    logic          accept;

    sync_2ff #(.W(WP)) u_rsync (
        .clk_i  (wclk),
        .rst_ni (wrst_n),
        .d_i    (rptr_gray),
        .q_o    (rq2)
    );

    assign accept  = winc & ~wfull_q;
    assign wbin_d  = wbin_q + WP'(accept);
    assign wgray_d = (wbin_d >> 1) ^ wbin_d;
    // Full when the next pointer is exactly one lap ahead of the synced read pointer
    assign wfull_d = (wgray_d == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]});

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            wfull_q <= 1'b0;
            wovf_q  <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            wfull_q <= wfull_d;
            wovf_q  <= winc & wfull_q;
        end
    end

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [WP-1:0] AF_T = WP'(AF_THRESH);

    logic [WP-1:0] rbin_s;
    logic [WP-1:0] fill;
    logic          walmost_full_q;
    logic          walmost_full_d;

    always_comb begin
        rbin_s = '0;
        rbin_s[WP-1] = rq2[WP-1];
        for (int i = WP - 2; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ rq2[i];
        end
    end

    assign fill           = wbin_d - rbin_s;
    assign walmost_full_d = (fill >= AF_T) | wfull_d;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            walmost_full_q <= 1'b0;
        end else begin
            walmost_full_q <= walmost_full_d;
        end
    end

    assign walmost_full = walmost_full_q;
`endif

    assign waddr     = wbin_q[ADDR_W-1:0];
    assign wen       = winc & ~wfull_q;
    assign wptr_gray = wgray_q;
    assign wfull     = wfull_q;
    assign wovf      = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomised scoreboard bench for the FIFO write pointer / full stage.
// Expected values come from an occupancy model driven by push and read counts.
module tb_fifo_wptr_full;

    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;
    localparam int MOD   = 2 * DEPTH;
    localparam int AF    = DEPTH - 2;

    logic          wclk = 1'b0;
    logic          wrst_n = 1'b0;
    logic          winc = 1'b0;
    logic [AW:0]   rptr_gray = '0;
    logic [AW-1:0] waddr;
    logic          wen;
    logic [AW:0]   wptr_gray;
    logic          wfull;
    logic          wovf;
`ifdef FIFO_ALMOST_FULL_EN
    logic          walmost_full;
`endif

    fifo_wptr_full #(.ADDR_W(AW)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .rptr_gray    (rptr_gray),
        .waddr        (waddr),
        .wen          (wen),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
`ifdef FIFO_ALMOST_FULL_EN
        .walmost_full (walmost_full),
`endif
        .wovf         (wovf)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int addr;
        int gray;
        int full;
        int ovf;
        int af;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model: pushes written so far, reads made, and read counts seen after sync lag
    int   wcnt = 0;
    int   rcnt = 0;
    int   m_full = 0;
    int   seen_q[$];

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & (MOD - 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge wclk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("waddr", int'(waddr), e.addr);
            chk("wptr_gray", int'(wptr_gray), e.gray);
            chk("wfull", int'(wfull), e.full);
            chk("wovf", int'(wovf), e.ovf);
`ifdef FIFO_ALMOST_FULL_EN
            chk("walmost_full", int'(walmost_full), e.af);
`endif
        end
    end

    task automatic step(input bit inc, input bit rst);
        exp_t e;
        int   fill;
        int   r;
        @(negedge wclk);
        winc      = inc;
        wrst_n    = ~rst;
        rptr_gray = (AW + 1)'(to_gray(rcnt));
        #1;
        if (!rst) chk("wen", int'(wen), int'(inc && !m_full));
        e.ovf = 0;
        if (rst) begin
            wcnt   = 0;
            m_full = 0;
            seen_q = '{0, 0};
            e.af   = 0;
        end else begin
            e.ovf = (inc && m_full) ? 1 : 0;
            if (inc && !m_full) wcnt = (wcnt + 1) % MOD;
            r      = seen_q.pop_front();
            seen_q.push_back(rcnt);
            fill   = (wcnt - r + MOD) % MOD;
            m_full = (fill == DEPTH) ? 1 : 0;
            e.af   = (fill >= AF || m_full != 0) ? 1 : 0;
        end
        e.addr = wcnt % DEPTH;
        e.gray = to_gray(wcnt);
        e.full = m_full;
        exp_q.push_back(e);
    endtask

    initial begin
        seen_q = '{0, 0};
        // reset held with a push pending
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        // fill from empty, then overflow attempts
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        // one read frees a slot; flag clears after the sync lag
        rcnt = 1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        // random traffic with a reader that trails the writer
        for (int i = 0; i < 400; i++) begin
            if (rcnt != wcnt && $urandom_range(0, 99) < 40)
                rcnt = (rcnt + 1) % MOD;
            if (i == 250) begin
                rcnt = 0;
                step(1'b1, 1'b1);
            end else begin
                step(($urandom_range(0, 99) < 60), 1'b0);
            end
        end
        // tracking reader: many pushes wrap the counter without filling
        for (int i = 0; i < 40; i++) begin
            if (rcnt != wcnt) rcnt = (rcnt + 1) % MOD;
            step(1'b1, 1'b0);
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge wclk);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
